// File: rtl/nfifo2mem_rd_sched_pkg.sv
// Shared types and width helpers for the NFIFO2MEM read scheduler.
package nfifo2mem_rd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN,
        RELEASE
    } t_sched_state;

    function automatic int flow_w(input int flows);
        return $clog2(flows);
    endfunction

    function automatic int stat_w(input int bsize);
        return $clog2(bsize) + 1;
    endfunction

endpackage

// File: rtl/nfifo2mem_rd_sched_rr_arb.sv
// Round-robin arbiter: lowest offset after last_grant wins.
module nfifo2mem_rd_sched_rr_arb
    import nfifo2mem_rd_sched_pkg::*;
#(
    parameter int FLOWS = 4,
    parameter int FW    = flow_w(FLOWS)
) (
    input  logic [FLOWS-1:0] req,
    input  logic [FW-1:0]    last_grant,
    output logic [FW-1:0]    gnt,
    output logic             any_gnt
);

    // Offset FLOWS truncates to 0, so last_grant itself is lowest priority.
    always_comb begin
        gnt     = '0;
        any_gnt = |req;
        for (int i = FLOWS; i >= 1; i--) begin
            if (req[last_grant + FW'(i)]) begin
                gnt = last_grant + FW'(i);
            end
        end
    end

endmodule

// File: rtl/nfifo2mem_rd_sched.sv
// Read-side scheduler: round-robin burst reads from per-flow blocks,
// framed output stream with backpressure, and per-burst space release.
module nfifo2mem_rd_sched
    import nfifo2mem_rd_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int FLOWS       = 4,
    parameter int BLOCK_SIZE  = 512,
    parameter int MAX_BURST   = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                                 CLK,
    input  logic                                 RESET,
    input  logic [FLOWS-1:0]                     MEM_EMPTY,
    input  logic [FLOWS*stat_w(BLOCK_SIZE)-1:0]  MEM_STATUS,
    output logic [flow_w(FLOWS)-1:0]             MEM_BLOCK_ADDR,
    output logic [$clog2(BLOCK_SIZE)-1:0]        MEM_RD_ADDR,
    output logic                                 MEM_READ,
    output logic                                 MEM_PIPE_EN,
    input  logic [DATA_WIDTH-1:0]                MEM_DATA_OUT,
    input  logic                                 MEM_DATA_VLD,
    output logic [FLOWS*stat_w(BLOCK_SIZE)-1:0]  MEM_REL_LEN,
    output logic [FLOWS-1:0]                     MEM_REL_LEN_DV,
    output logic [DATA_WIDTH-1:0]                TX_DATA,
    output logic [flow_w(FLOWS)-1:0]             TX_FLOW,
    output logic                                 TX_SOP,
    output logic                                 TX_EOP,
    output logic                                 TX_VLD,
    input  logic                                 TX_RDY
);

    localparam int FW = flow_w(FLOWS);
    localparam int SW = stat_w(BLOCK_SIZE);
    localparam int AW = SW - 1;
    localparam logic [SW-1:0] MAXB = SW'(MAX_BURST);
    localparam logic [SW-1:0] ONE  = SW'(1);

    t_sched_state     state_q, state_d;
    logic [FW-1:0]    flow_q, flow_d;
    logic [FW-1:0]    last_q, last_d;
    logic [SW-1:0]    len_q, len_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    ptr_q [FLOWS];
    logic [AW-1:0]    ptr_d [FLOWS];
    logic [FLOWS-1:0] rel_dv_q, rel_dv_d;
    logic [FLOWS*SW-1:0] rel_len_q, rel_len_d;

    logic [FW-1:0]          sb_flow_q [MEM_LATENCY];
    logic [FW-1:0]          sb_flow_d [MEM_LATENCY];
    logic [MEM_LATENCY-1:0] sb_sop_q, sb_sop_d;
    logic [MEM_LATENCY-1:0] sb_eop_q, sb_eop_d;

    logic [FLOWS-1:0] req;
    logic [FW-1:0]    gnt;
    logic             any_gnt;
    logic [SW-1:0]    gnt_stat;
    logic             rd;
    logic             eop_xfer;

    always_comb begin
        for (int i = 0; i < FLOWS; i++) begin
            req[i] = !MEM_EMPTY[i] && (MEM_STATUS[i*SW +: SW] != '0);
        end
    end

    nfifo2mem_rd_sched_rr_arb #(
        .FLOWS (FLOWS),
        .FW    (FW)
    ) u_arb (
        .req        (req),
        .last_grant (last_q),
        .gnt        (gnt),
        .any_gnt    (any_gnt)
    );

    assign gnt_stat = MEM_STATUS[gnt*SW +: SW];
    assign eop_xfer = MEM_DATA_VLD && TX_RDY && TX_EOP;

    always_comb begin
        state_d   = state_q;
        flow_d    = flow_q;
        last_d    = last_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        rel_dv_d  = '0;
        rel_len_d = '0;
        rd        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_gnt) begin
                    flow_d  = gnt;
                    len_d   = (gnt_stat > MAXB) ? MAXB : gnt_stat;
                    cnt_d   = (gnt_stat > MAXB) ? MAXB : gnt_stat;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (TX_RDY) begin
                    rd            = 1'b1;
                    ptr_d[flow_q] = ptr_q[flow_q] + 1'b1;
                    cnt_d         = cnt_q - 1'b1;
                    if (cnt_q == ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (eop_xfer) begin
                    rel_dv_d[flow_q]            = 1'b1;
                    rel_len_d[flow_q*SW +: SW] = len_q;
                    state_d                     = RELEASE;
                end
            end
            RELEASE: begin
                last_d  = flow_q;
                state_d = IDLE;
            end
        endcase
    end

    // Sideband tags ride alongside the memory pipeline, frozen with it.
    always_comb begin
        sb_flow_d = sb_flow_q;
        sb_sop_d  = sb_sop_q;
        sb_eop_d  = sb_eop_q;
        if (TX_RDY) begin
            sb_flow_d[0] = flow_q;
            sb_sop_d[0]  = rd && (cnt_q == len_q);
            sb_eop_d[0]  = rd && (cnt_q == ONE);
            for (int k = 1; k < MEM_LATENCY; k++) begin
                sb_flow_d[k] = sb_flow_q[k-1];
                sb_sop_d[k]  = sb_sop_q[k-1];
                sb_eop_d[k]  = sb_eop_q[k-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            flow_q    <= '0;
            last_q    <= FW'(FLOWS - 1);
            len_q     <= '0;
            cnt_q     <= '0;
            rel_dv_q  <= '0;
            rel_len_q <= '0;
            sb_sop_q  <= '0;
            sb_eop_q  <= '0;
            for (int i = 0; i < FLOWS; i++) begin
                ptr_q[i] <= '0;
            end
            for (int k = 0; k < MEM_LATENCY; k++) begin
                sb_flow_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            flow_q    <= flow_d;
            last_q    <= last_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            rel_dv_q  <= rel_dv_d;
            rel_len_q <= rel_len_d;
            sb_sop_q  <= sb_sop_d;
            sb_eop_q  <= sb_eop_d;
            ptr_q     <= ptr_d;
            sb_flow_q <= sb_flow_d;
        end
    end

    assign MEM_READ       = rd;
    assign MEM_BLOCK_ADDR = flow_q;
    assign MEM_RD_ADDR    = ptr_q[flow_q];
    assign MEM_PIPE_EN    = TX_RDY;
    assign MEM_REL_LEN    = rel_len_q;
    assign MEM_REL_LEN_DV = rel_dv_q;
    assign TX_DATA        = MEM_DATA_OUT;
    assign TX_VLD         = MEM_DATA_VLD;
    assign TX_FLOW        = sb_flow_q[MEM_LATENCY-1];
    assign TX_SOP         = sb_sop_q[MEM_LATENCY-1];
    assign TX_EOP         = sb_eop_q[MEM_LATENCY-1];

endmodule

// File: tb/tb_nfifo2mem_rd_sched.sv
// Directed bench for nfifo2mem_rd_sched with an upstream buffer and
// single-latency memory model.
module tb_nfifo2mem_rd_sched;

    localparam int DW = 64;
    localparam int FL = 4;
    localparam int BS = 512;
    localparam int MB = 16;
    localparam int LAT = 1;
    localparam int FW = 2;
    localparam int AW = 9;
    localparam int SW = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [FL-1:0]     mem_empty;
    logic [FL*SW-1:0]  mem_status;
    logic [FW-1:0]     blk;
    logic [AW-1:0]     rd_addr;
    logic              rd;
    logic              pipe_en;
    logic [DW-1:0]     mem_dout;
    logic              mem_vld;
    logic [FL*SW-1:0]  rel_len;
    logic [FL-1:0]     rel_dv;
    logic [DW-1:0]     tx_data;
    logic [FW-1:0]     tx_flow;
    logic              tx_sop;
    logic              tx_eop;
    logic              tx_vld;
    logic              tx_rdy = 1'b1;

    logic [FL-1:0]     ld_mask = '0;
    int unsigned       ld_val = 0;
    int unsigned       st [FL];

    logic [FW+AW-1:0]  rdq [$];
    logic [DW+FW+1:0]  txq [$];
    logic [FL+SW-1:0]  relq [$];
    int                viol = 0;
    int                multi = 0;

    int                n_chk = 0;
    int                n_err = 0;
    logic [15:0]       pat = 16'b1011_0010_1110_0101;

    always #5 clk = ~clk;

    nfifo2mem_rd_sched #(
        .DATA_WIDTH  (DW),
        .FLOWS       (FL),
        .BLOCK_SIZE  (BS),
        .MAX_BURST   (MB),
        .MEM_LATENCY (LAT)
    ) dut (
        .CLK            (clk),
        .RESET          (rst_n),
        .MEM_EMPTY      (mem_empty),
        .MEM_STATUS     (mem_status),
        .MEM_BLOCK_ADDR (blk),
        .MEM_RD_ADDR    (rd_addr),
        .MEM_READ       (rd),
        .MEM_PIPE_EN    (pipe_en),
        .MEM_DATA_OUT   (mem_dout),
        .MEM_DATA_VLD   (mem_vld),
        .MEM_REL_LEN    (rel_len),
        .MEM_REL_LEN_DV (rel_dv),
        .TX_DATA        (tx_data),
        .TX_FLOW        (tx_flow),
        .TX_SOP         (tx_sop),
        .TX_EOP         (tx_eop),
        .TX_VLD         (tx_vld),
        .TX_RDY         (tx_rdy)
    );

    function automatic logic [DW-1:0] word(input logic [FW-1:0] b, input logic [AW-1:0] a);
        return 64'hC0DE_0000_0000_0000 | (64'(b) << 16) | 64'(a);
    endfunction

    // Upstream buffer occupancy and memory read pipeline.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL; i++) st[i] <= 0;
            mem_vld  <= 1'b0;
            mem_dout <= '0;
        end else begin
            for (int i = 0; i < FL; i++) begin
                if (ld_mask[i]) st[i] <= ld_val;
                else if (rel_dv[i]) st[i] <= st[i] - int'(rel_len[i*SW +: SW]);
            end
            if (pipe_en) begin
                mem_vld  <= rd;
                mem_dout <= word(blk, rd_addr);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < FL; i++) begin
            mem_empty[i]            = (st[i] == 0);
            mem_status[i*SW +: SW] = SW'(st[i]);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd) rdq.push_back({blk, rd_addr});
            if (rd && !tx_rdy) viol++;
            if (tx_vld && tx_rdy) txq.push_back({tx_flow, tx_sop, tx_eop, tx_data});
            if ($countones(rel_dv) > 1) multi++;
            for (int i = 0; i < FL; i++) begin
                if (!rel_dv[i] && rel_len[i*SW +: SW] != '0) multi++;
                if (rel_dv[i]) relq.push_back({rel_dv, rel_len[i*SW +: SW]});
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [FL-1:0] m, input int unsigned v);
        ld_mask = m;
        ld_val  = v;
        @(posedge clk);
        #1;
        ld_mask = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_rel(input int n, input int budget, input bit rnd);
        int c;
        c = 0;
        while (relq.size() < n && c < budget) begin
            tx_rdy = rnd ? pat[c % 16] : 1'b1;
            @(posedge clk);
            #1;
            c++;
        end
        tx_rdy = 1'b1;
        check("timeout", 128'(c < budget), 128'(1));
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int rb, db, tb0, v0;
        int unsigned ep [FL];
        logic [FW-1:0] f;

        #12;
        check("rst_read", 128'(rd), 128'(0));
        check("rst_blk", 128'(blk), 128'(0));
        check("rst_addr", 128'(rd_addr), 128'(0));
        check("rst_reldv", 128'(rel_dv), 128'(0));
        check("rst_rellen", 128'(rel_len), 128'(0));
        check("rst_tx", 128'({tx_flow, tx_sop, tx_eop}), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single flow, 5 words.
        rb = relq.size(); db = rdq.size(); tb0 = txq.size();
        load(4'b0100, 5);
        wait_rel(rb + 1, 200, 1'b0);
        check("t1_nrd", 128'(rdq.size() - db), 128'(5));
        for (int j = 0; j < 5; j++) begin
            check("t1_rd", 128'(rdq[db+j]), 128'({2'd2, 9'(j)}));
            check("t1_tx", 128'(txq[tb0+j]), 128'({2'd2, j == 0, j == 4, word(2'd2, 9'(j))}));
        end
        check("t1_nrel", 128'(relq.size() - rb), 128'(1));
        check("t1_rel", 128'(relq[rb]), 128'({4'b0100, 10'd5}));

        // All flows full: round robin, capped bursts.
        do_reset();
        rb = relq.size(); db = rdq.size(); tb0 = txq.size();
        load(4'b1111, 40);
        wait_rel(rb + 12, 600, 1'b0);
        for (int k = 0; k < 12; k++) begin
            check("t2_rel", 128'(relq[rb+k]),
                  128'({4'(1 << (k % 4)), (k < 8) ? 10'd16 : 10'd8}));
        end
        check("t2_nrd", 128'(rdq.size() - db), 128'(160));
        check("t2_ntx", 128'(txq.size() - tb0), 128'(160));
        for (int i = 0; i < FL; i++) ep[i] = 0;
        for (int j = db; j < rdq.size(); j++) begin
            f = rdq[j][AW +: FW];
            check("t2_addr", 128'(rdq[j][AW-1:0]), 128'(ep[f]));
            ep[f]++;
        end

        // Pointer wrap on flow 1.
        do_reset();
        rb = relq.size();
        load(4'b0010, 509);
        wait_rel(rb + 32, 1500, 1'b0);
        rb = relq.size(); db = rdq.size();
        load(4'b0010, 6);
        wait_rel(rb + 1, 200, 1'b0);
        for (int j = 0; j < 6; j++) begin
            check("t3_rd", 128'(rdq[db+j]), 128'({2'd1, 9'((509 + j) % 512)}));
        end
        check("t3_rel", 128'(relq[rb]), 128'({4'b0010, 10'd6}));

        // Backpressure toggling across a full burst.
        rb = relq.size(); db = rdq.size(); tb0 = txq.size(); v0 = viol;
        load(4'b0001, 16);
        wait_rel(rb + 1, 400, 1'b1);
        check("t4_viol", 128'(viol - v0), 128'(0));
        check("t4_ntx", 128'(txq.size() - tb0), 128'(16));
        for (int j = 0; j < 16; j++) begin
            check("t4_tx", 128'(txq[tb0+j]), 128'({2'd0, j == 0, j == 15, word(2'd0, 9'(j))}));
        end
        check("t4_rel", 128'(relq[rb]), 128'({4'b0001, 10'd16}));

        // Single-word burst on flow 3.
        rb = relq.size(); tb0 = txq.size();
        load(4'b1000, 1);
        wait_rel(rb + 1, 200, 1'b0);
        check("t5_ntx", 128'(txq.size() - tb0), 128'(1));
        check("t5_tx", 128'(txq[tb0]), 128'({2'd3, 1'b1, 1'b1, word(2'd3, 9'd0)}));
        check("t5_rel", 128'(relq[rb]), 128'({4'b1000, 10'd1}));

        // Reset mid-burst.
        rb = relq.size();
        load(4'b0100, 16);
        repeat (5) @(posedge clk);
        #1;
        check("t6_rd_mid", 128'(rd), 128'(1));
        rst_n = 1'b0;
        #1;
        check("t6_rd_async", 128'(rd), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t6_norel", 128'(relq.size() - rb), 128'(0));
        db = rdq.size();
        load(4'b0011, 2);
        wait_rel(rb + 2, 200, 1'b0);
        check("t6_first", 128'(rdq[db]), 128'({2'd0, 9'd0}));
        check("t6_rel", 128'(relq[rb]), 128'({4'b0001, 10'd2}));
        check("rel_onehot", 128'(multi), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
